// File: rtl/z80_pkg.sv
// Shared constants and types for the Z80 interrupt daisy-chain controller and its RETI decoder.
package z80_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] OP_ED            = 8'hED;
    localparam logic [BYTE_W-1:0] OP_RETI          = 8'h4D;
    localparam logic [BYTE_W-1:0] SPURIOUS_VEC_DEF = 8'hFF;

    typedef enum logic {
        RETI_IDLE,
        RETI_GOT_ED
    } reti_state_e;

endpackage

// File: rtl/z80_int_daisy_if.sv
// CPU bus and peripheral interrupt signals of the daisy-chain controller.
interface z80_int_daisy_if #(
    parameter int unsigned N = 4
);
    logic             m1_n;
    logic             iorq_n;
    logic             rd_n;
    logic [7:0]       cpu_din;
    logic [N-1:0]     irq_req;
    logic [8*N-1:0]   irq_vec;
    logic             int_n;
    logic             oe;
    logic [7:0]       dout;
    logic [N-1:0]     int_ack;
    logic [N-1:0]     int_reti;
    logic [N-1:0]     in_service;

    modport slave (
        input  m1_n, iorq_n, rd_n, cpu_din, irq_req, irq_vec,
        output int_n, oe, dout, int_ack, int_reti, in_service
    );

    modport master (
        output m1_n, iorq_n, rd_n, cpu_din, irq_req, irq_vec,
        input  int_n, oe, dout, int_ack, int_reti, in_service
    );
endinterface

// File: rtl/z80_reti_decoder.sv
// Watches M1 opcode fetches for the ED 4D (RETI) sequence; one strobe per fetch
// regardless of how many cycles the fetch is stretched.
module z80_reti_decoder
    import z80_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en_i,
    input  logic              m1_n_i,
    input  logic              rd_n_i,
    input  logic [BYTE_W-1:0] din_i,
    output logic              reti_evt_c
);

    reti_state_e state_q, state_d;
    logic        fetch_q, fetch_d;
    logic        fetch;
    logic        strobe;

    assign fetch  = ~m1_n_i & ~rd_n_i;
    assign strobe = clk_en_i & fetch & ~fetch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RETI_IDLE;
            fetch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_d    = fetch_q;
        reti_evt_c = 1'b0;
        if (clk_en_i) begin
            fetch_d = fetch;
        end
        if (strobe) begin
            case (state_q)
                RETI_IDLE: begin
                    if (din_i == OP_ED) state_d = RETI_GOT_ED;
                end
                RETI_GOT_ED: begin
                    if (din_i == OP_RETI) begin
                        reti_evt_c = 1'b1;
                        state_d    = RETI_IDLE;
                    end else if (din_i == OP_ED) begin
                        state_d = RETI_GOT_ED;
                    end else begin
                        state_d = RETI_IDLE;
                    end
                end
                default: state_d = RETI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/z80_int_daisy.sv
// Fixed-priority interrupt scheduler replacing the Z80 IEI/IEO chain: drives int_n,
// supplies the acknowledge vector and retires in-service levels on RETI.
module z80_int_daisy
    import z80_pkg::*;
#(
    parameter int unsigned       N            = 4,
    parameter logic [BYTE_W-1:0] SPURIOUS_VEC = SPURIOUS_VEC_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clock_ena,
    z80_int_daisy_if.slave  bus
);

    logic [N-1:0]      in_service_q, in_service_d;
    logic [N-1:0]      int_ack_q, int_ack_d;
    logic [N-1:0]      int_reti_q, int_reti_d;
    logic              int_n_q, int_n_d;
    logic              intack_q, intack_d;
    logic              lat_valid_q, lat_valid_d;
    logic [BYTE_W-1:0] lat_vec_q, lat_vec_d;

    logic              intack;
    logic              intack_rise;
    logic              reti_evt;
    logic [N-1:0]      elig;
    logic [N-1:0]      win_oh;
    logic [N-1:0]      clr_oh;
    logic [BYTE_W-1:0] win_vec;
    logic              any_elig;
    logic              blocked;
    logic              win_found;
    logic              clr_found;

    assign intack      = ~bus.m1_n & ~bus.iorq_n;
    assign intack_rise = intack & ~intack_q;

    z80_reti_decoder u_reti (
        .clk        (clock),
        .rst_n      (reset_n),
        .clk_en_i   (clock_ena),
        .m1_n_i     (bus.m1_n),
        .rd_n_i     (bus.rd_n),
        .din_i      (bus.cpu_din),
        .reti_evt_c (reti_evt)
    );

    // A device is blocked by its own or any higher-priority in-service level.
    always_comb begin
        elig      = '0;
        win_oh    = '0;
        clr_oh    = '0;
        win_vec   = SPURIOUS_VEC;
        blocked   = 1'b0;
        win_found = 1'b0;
        clr_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            blocked = blocked | in_service_q[i];
            elig[i] = bus.irq_req[i] & ~blocked;
            if (elig[i] && !win_found) begin
                win_found = 1'b1;
                win_oh[i] = 1'b1;
                win_vec   = bus.irq_vec[i*BYTE_W +: BYTE_W];
            end
            if (in_service_q[i] && !clr_found) begin
                clr_found = 1'b1;
                clr_oh[i] = 1'b1;
            end
        end
        any_elig = win_found;
    end

    // RETI clear is applied before the acknowledge set, so a same-bit collision leaves it set.
    always_comb begin
        in_service_d = in_service_q;
        int_ack_d    = int_ack_q;
        int_reti_d   = int_reti_q;
        int_n_d      = int_n_q;
        intack_d     = intack_q;
        lat_valid_d  = lat_valid_q;
        lat_vec_d    = lat_vec_q;
        if (clock_ena) begin
            int_ack_d  = '0;
            int_reti_d = '0;
            intack_d   = intack;
            int_n_d    = ~any_elig;
            if (reti_evt && clr_found) begin
                in_service_d = in_service_d & ~clr_oh;
                int_reti_d   = clr_oh;
            end
            if (intack_rise) begin
                lat_valid_d = any_elig;
                lat_vec_d   = win_vec;
                if (any_elig) begin
                    in_service_d = in_service_d | win_oh;
                    int_ack_d    = win_oh;
                    int_n_d      = 1'b1;
                end
            end else if (!intack) begin
                lat_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_service_q <= '0;
            int_ack_q    <= '0;
            int_reti_q   <= '0;
            int_n_q      <= 1'b1;
            intack_q     <= 1'b0;
            lat_valid_q  <= 1'b0;
            lat_vec_q    <= SPURIOUS_VEC;
        end else begin
            in_service_q <= in_service_d;
            int_ack_q    <= int_ack_d;
            int_reti_q   <= int_reti_d;
            int_n_q      <= int_n_d;
            intack_q     <= intack_d;
            lat_valid_q  <= lat_valid_d;
            lat_vec_q    <= lat_vec_d;
        end
    end

    assign bus.int_n      = int_n_q;
    assign bus.int_ack    = int_ack_q;
    assign bus.int_reti   = int_reti_q;
    assign bus.in_service = in_service_q;
    assign bus.oe         = intack & lat_valid_q;
    assign bus.dout       = (intack & lat_valid_q) ? lat_vec_q : SPURIOUS_VEC;

endmodule

// File: tb/tb_z80_int_daisy.sv
// Directed self-checking bench for z80_int_daisy with four devices.
module tb_z80_int_daisy;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clock_ena;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] reti_seen;
    int           reti_pulses;

    z80_int_daisy_if #(.N(N)) bus ();

    z80_int_daisy #(.N(N), .SPURIOUS_VEC(8'hFF)) dut (
        .clock     (clk),
        .reset_n   (rst_n),
        .clock_ena (clock_ena),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_reti();
        if (bus.int_reti != '0) begin
            reti_seen = reti_seen | bus.int_reti;
            reti_pulses++;
        end
    endtask

    // Opcode fetch stretched over two enabled clocks, then M1 released.
    task automatic fetch(input logic [7:0] op);
        bus.m1_n    = 1'b0;
        bus.rd_n    = 1'b0;
        bus.cpu_din = op;
        repeat (2) begin
            tick();
            sample_reti();
        end
        bus.m1_n = 1'b1;
        bus.rd_n = 1'b1;
        tick();
        sample_reti();
    endtask

    task automatic reti();
        reti_seen   = '0;
        reti_pulses = 0;
        fetch(8'hED);
        fetch(8'h4D);
    endtask

    task automatic ack_begin();
        bus.m1_n   = 1'b0;
        bus.iorq_n = 1'b0;
        tick();
    endtask

    task automatic ack_end();
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        clock_ena   = 1'b1;
        bus.m1_n    = 1'b1;
        bus.iorq_n  = 1'b1;
        bus.rd_n    = 1'b1;
        bus.cpu_din = 8'h00;
        bus.irq_req = '0;
        bus.irq_vec = {8'h60, 8'h40, 8'h20, 8'h08};
        reti_seen   = '0;
        reti_pulses = 0;

        repeat (2) tick();
        check("rst int_n", 32'(bus.int_n), 32'h1);
        check("rst oe", 32'(bus.oe), 32'h0);
        check("rst dout", 32'(bus.dout), 32'hFF);
        check("rst in_service", 32'(bus.in_service), 32'h0);
        check("rst int_ack", 32'(bus.int_ack), 32'h0);
        check("rst int_reti", 32'(bus.int_reti), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single request from device 2
        bus.irq_req = 4'b0100;
        check("single int_n pre", 32'(bus.int_n), 32'h1);
        tick();
        check("single int_n", 32'(bus.int_n), 32'h0);
        ack_begin();
        check("single ack", 32'(bus.int_ack), 32'h4);
        check("single isr", 32'(bus.in_service), 32'h4);
        check("single oe", 32'(bus.oe), 32'h1);
        check("single dout", 32'(bus.dout), 32'h40);
        check("single int_n ack", 32'(bus.int_n), 32'h1);
        tick();
        check("single ack pulse", 32'(bus.int_ack), 32'h0);
        check("single int_n held", 32'(bus.int_n), 32'h1);
        ack_end();
        check("single oe end", 32'(bus.oe), 32'h0);
        check("single dout end", 32'(bus.dout), 32'hFF);
        bus.irq_req = 4'b0000;
        reti();
        check("single reti", 32'(reti_seen), 32'h4);
        check("single reti pulses", 32'(reti_pulses), 32'h1);
        check("single isr clr", 32'(bus.in_service), 32'h0);

        // Priority between devices 1 and 3
        bus.irq_req = 4'b1010;
        tick();
        check("prio int_n", 32'(bus.int_n), 32'h0);
        ack_begin();
        check("prio ack1", 32'(bus.int_ack), 32'h2);
        check("prio dout1", 32'(bus.dout), 32'h20);
        check("prio isr1", 32'(bus.in_service), 32'h2);
        tick();
        check("prio int_n blocked", 32'(bus.int_n), 32'h1);
        ack_end();
        bus.irq_req = 4'b1000;
        reti();
        check("prio reti1", 32'(reti_seen), 32'h2);
        check("prio int_n reassert", 32'(bus.int_n), 32'h0);
        ack_begin();
        check("prio ack3", 32'(bus.int_ack), 32'h8);
        check("prio dout3", 32'(bus.dout), 32'h60);
        check("prio isr3", 32'(bus.in_service), 32'h8);
        ack_end();
        bus.irq_req = 4'b0000;
        reti();
        check("prio reti3", 32'(reti_seen), 32'h8);

        // Nesting: device 0 interrupts device 2's service
        bus.irq_req = 4'b0100;
        tick();
        ack_begin();
        ack_end();
        bus.irq_req = 4'b0001;
        tick();
        check("nest int_n", 32'(bus.int_n), 32'h0);
        ack_begin();
        check("nest ack0", 32'(bus.int_ack), 32'h1);
        check("nest dout0", 32'(bus.dout), 32'h08);
        check("nest isr", 32'(bus.in_service), 32'h5);
        ack_end();
        bus.irq_req = 4'b1000;
        tick();
        check("nest dev3 blocked", 32'(bus.int_n), 32'h1);
        reti();
        check("nest reti0", 32'(reti_seen), 32'h1);
        check("nest isr after1", 32'(bus.in_service), 32'h4);
        check("nest dev3 still blocked", 32'(bus.int_n), 32'h1);
        reti();
        check("nest reti2", 32'(reti_seen), 32'h4);
        check("nest isr after2", 32'(bus.in_service), 32'h0);
        check("nest dev3 int_n", 32'(bus.int_n), 32'h0);
        ack_begin();
        check("nest ack3", 32'(bus.int_ack), 32'h8);
        ack_end();
        bus.irq_req = 4'b0000;
        reti();

        // RETI decode edge cases
        bus.irq_req = 4'b0010;
        tick();
        ack_begin();
        ack_end();
        bus.irq_req = 4'b0000;
        reti_seen   = '0;
        reti_pulses = 0;
        fetch(8'hED);
        fetch(8'hED);
        fetch(8'h4D);
        check("ed-ed-4d reti", 32'(reti_seen), 32'h2);
        check("ed-ed-4d pulses", 32'(reti_pulses), 32'h1);
        bus.irq_req = 4'b0010;
        tick();
        ack_begin();
        ack_end();
        bus.irq_req = 4'b0000;
        reti_seen   = '0;
        reti_pulses = 0;
        fetch(8'hED);
        fetch(8'h00);
        fetch(8'h4D);
        check("ed-00-4d pulses", 32'(reti_pulses), 32'h0);
        check("ed-00-4d isr", 32'(bus.in_service), 32'h2);
        reti();
        check("cleanup reti", 32'(reti_seen), 32'h2);
        reti();
        check("idle reti pulses", 32'(reti_pulses), 32'h0);
        check("idle reti isr", 32'(bus.in_service), 32'h0);

        // Request dropped, then a spurious acknowledge
        bus.irq_req = 4'b0001;
        tick();
        check("drop int_n asserted", 32'(bus.int_n), 32'h0);
        bus.irq_req = 4'b0000;
        tick();
        check("drop int_n released", 32'(bus.int_n), 32'h1);
        ack_begin();
        check("spur oe", 32'(bus.oe), 32'h0);
        check("spur dout", 32'(bus.dout), 32'hFF);
        check("spur ack", 32'(bus.int_ack), 32'h0);
        check("spur isr", 32'(bus.in_service), 32'h0);
        ack_end();

        // Asynchronous reset in the middle of an acknowledge
        bus.irq_req = 4'b0100;
        tick();
        ack_begin();
        check("arst oe before", 32'(bus.oe), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst oe", 32'(bus.oe), 32'h0);
        check("arst dout", 32'(bus.dout), 32'hFF);
        check("arst isr", 32'(bus.in_service), 32'h0);
        check("arst int_n", 32'(bus.int_n), 32'h1);
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b1;
        clock_ena  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("ena low holds int_n", 32'(bus.int_n), 32'h1);
        clock_ena = 1'b1;
        tick();
        check("arst reassert int_n", 32'(bus.int_n), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_int_daisy.md
Name: z80_int_daisy

Overview:
- Interrupt-chain controller for the Z80 subsystem. It arbitrates interrupt requests from up to N peripherals (PIO ports A/B, CTC channels, SIO) onto a single int_n.
- During the CPU interrupt-acknowledge cycle it places the winning device's vector on the bus.
- It decodes RETI (ED 4D) on the opcode stream to retire in-service levels.
- It replaces the per-peripheral IEI/IEO chain with one fixed-priority scheduler; index 0 has the highest priority.

Parameters:
- N, 4, number of requesting devices (1..8)
- SPURIOUS_VEC, 8'hFF, byte driven when an acknowledge finds no eligible request

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clock_ena  in  1  CPU clock enable; all state advances only when high
- m1_n  in  1  CPU M1
- iorq_n  in  1  CPU IORQ
- rd_n  in  1  CPU RD
- cpu_din  in  8  CPU input-bus mirror, used for RETI decode
- irq_req  in  N  level request per device, held until acknowledged
- irq_vec  in  8*N  vector per device; device i at bits [8i+7:8i]
- int_n  out  1  CPU interrupt, active low, registered
- oe  out  1  drive dout onto the CPU bus
- dout  out  8  vector byte
- int_ack  out  N  one-cycle pulse to the device that won the acknowledge
- int_reti  out  N  one-cycle pulse to the device whose level RETI retired
- in_service  out  N  in-service status

Behaviour:
- Reset (reset_n low, asynchronous) clears: in_service=0, int_n=1, int_ack=0, int_reti=0, latched winner invalid, RETI FSM=IDLE, edge detector=0. oe=0 and dout=SPURIOUS_VEC follow combinationally.
- Reset asserted mid-acknowledge aborts it. No in_service bit remains set.
- Eligibility:
  - device i is eligible when irq_req[i]=1 and in_service[j]=0 for all j<=i.
  - winner = lowest-index eligible device.
- int_n is registered: int_n <= ~(any eligible). Assertion/deassertion latency is one enabled clock after irq_req or in_service changes.
- A request dropped before the acknowledge deasserts int_n on the next enabled clock. No ack is issued.
- Intack detection: intack = !m1_n & !iorq_n. Its rising edge is detected with a registered copy, sampled on clock_ena.
- On the intack rising edge, if a winner exists:
  - latch its index and irq_vec byte
  - in_service[w] <= 1
  - int_ack[w] pulses for one enabled clock
  - int_n deasserts on the same edge.
- On the intack rising edge with no winner: latch "spurious". No state change and no ack.
- oe = intack & latched-valid.
- dout = latched vector during intack, SPURIOUS_VEC otherwise. dout is valid from the clock after the edge; the Z80 intack wait states cover this.
- The latch clears when intack deasserts.
- RETI FSM advances on clock_ena & !m1_n & !rd_n, once per M1 read: rising edge of the opcode-fetch strobe, so a stalled fetch counts once.
  - IDLE: ED -> GOT_ED; otherwise stay in IDLE.
  - GOT_ED: 4D -> RETI event, then IDLE; ED -> stay in GOT_ED; other -> IDLE.
- RETI event: clear the lowest-index set in_service bit and pulse int_reti for that bit. With in_service=0 it is ignored, with no pulse.
- Simultaneous RETI clear and intack set in one cycle: clear is applied first, then set. If both target the same bit, set wins.
- Only one in_service bit is set per acknowledge. Nesting is allowed only for strictly higher priority.

Decomposition:
- Shared package z80_pkg holds:
  - RETI opcode constants OP_ED=8'hED, OP_RETI=8'h4D
  - SPURIOUS_VEC default
  - the RETI FSM state enum {RETI_IDLE, RETI_GOT_ED}.
- One natural sub-module: z80_reti_decoder (M1 edge detect plus FSM, emits a reti_evt pulse). It can later be reused by the peripherals themselves.
- Priority encoder and vector mux stay inline.

Test Plan:
- Single request: irq_req=4'b0100 with irq_vec[2]=8'h40.
  - int_n falls 1 enabled clock later.
  - intack edge -> int_ack=4'b0100, in_service=4'b0100, oe=1, dout=8'h40, int_n=1.
- Priority: irq_req=4'b1010 simultaneously.
  - First intack returns the device-1 vector.
  - After fetch ED,4D: int_reti=4'b0010 and int_n re-asserts.
  - Second intack returns the device-3 vector.
- Nesting: device 2 in service, device 0 requests.
  - int_n asserts, intack gives device 0 and in_service=4'b0101.
  - RETI clears bit 0 only.
  - A device-3 request stays blocked until a second RETI clears bit 2.
- RETI decode edge cases:
  - fetch sequence ED,ED,4D gives one RETI
  - ED,00,4D gives none
  - RETI with in_service=0 gives no int_reti pulse.
- Spurious and request-drop:
  - irq_req drops before intack -> int_n=1 next clock
  - forced intack then gives oe=0, dout=8'hFF, no ack, in_service unchanged.
- Async reset mid-intack (oe=1): reset_n low -> immediately oe=0, in_service=0, int_n=1. After release, a held request re-asserts int_n in 1 clock.
